// File: rtl/shared_reg_arb_pkg.sv
// Shared definitions for the round-robin shared-register arbiter.
// Default parameter values, the lock FSM state type, the default-width index type
// and a small modulo-increment helper for the round-robin pointer.
package shared_reg_arb_pkg;

  localparam int              DEF_NREQ         = 4;
  localparam int              DEF_WIDTH        = 64;
  localparam int              DEF_LOCK_TIMEOUT = 16;
  localparam logic [DEF_WIDTH-1:0] DEF_INIT    = '0;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef logic [$clog2(DEF_NREQ)-1:0] idx_t;

  // Next round-robin position after idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first requester at or after ptr,
// wrapping modulo N. Outputs a one-hot grant, its index and an any-request flag.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] masked;
  logic [N-1:0] cand;

  // Prefer requesters at or above ptr; fall back to the whole vector to wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    hi_mask = '0;
    gnt     = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (i >= int'(ptr));
    end
    masked = req & hi_mask;
    cand   = (|masked) ? masked : req;
    // Scan downwards so the lowest set candidate wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Shared register written by NREQ valid/ready requesters under round-robin arbitration.
// At most one write commits per cycle; the register is broadcast on q_out.
// Optional owner locking with idle timeout is compiled in with SHARED_REG_ARB_LOCK_EN.
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int               NREQ         = DEF_NREQ,
  parameter int               WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] INIT         = '0,
  parameter int               LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
`ifdef SHARED_REG_ARB_LOCK_EN
  input  logic [NREQ-1:0]         req_lock,
  output logic                    lock_timeout,
`endif
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        q_out,
  output logic                    wr_fire,
  output logic [$clog2(NREQ)-1:0] wr_src
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]    ptr_q,  ptr_d;
  logic [WIDTH-1:0] q_q,    q_d;
  logic             fire_q, fire_d;
  logic [IW-1:0]    src_q,  src_d;

  logic [NREQ-1:0]  pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  logic [NREQ-1:0]  gnt;
  logic [IW-1:0]    win_idx;
  logic             win_any;
  logic             xfer;

  rr_priority_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef SHARED_REG_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          to_q,    to_d;

  // While locked only the owner may be granted; otherwise use the round-robin pick.
  always_comb begin
    gnt     = '0;
    win_idx = pick_idx;
    win_any = pick_any;
    if (state_q == LOCKED) begin
      gnt[owner_q] = req_valid[owner_q];
      win_idx      = owner_q;
      win_any      = req_valid[owner_q];
    end else begin
      gnt = pick_gnt;
    end
  end

  // Lock FSM next state: enter on a locking transfer, leave on an unlocking owner
  // transfer or after LOCK_TIMEOUT consecutive cycles without an owner transfer.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer && req_lock[win_idx]) begin
          state_d = LOCKED;
          owner_d = win_idx;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        if (xfer) begin
          cnt_d = '0;
          if (!req_lock[win_idx]) state_d = IDLE;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign lock_timeout = to_q;
`else
  // Plain per-cycle round-robin arbitration.
  always_comb begin
    gnt     = pick_gnt;
    win_idx = pick_idx;
    win_any = pick_any;
  end
`endif

  // Grants are suppressed during reset so a reset-cycle transfer is discarded.
  assign req_ready = RST ? '0 : gnt;
  assign xfer      = win_any & ~RST;

  // Commit the winner's data and advance the pointer past it on a transfer.
  always_comb begin
    q_d    = q_q;
    fire_d = 1'b0;
    src_d  = src_q;
    ptr_d  = ptr_q;
    if (xfer) begin
      q_d    = req_data[int'(win_idx) * WIDTH +: WIDTH];
      fire_d = 1'b1;
      src_d  = win_idx;
      ptr_d  = IW'(rr_next(32'(win_idx), NREQ));
    end
  end

  // All state (register, pointer, write report, lock FSM) with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (RST) begin
      q_q     <= INIT;
      ptr_q   <= '0;
      fire_q  <= 1'b0;
      src_q   <= '0;
`ifdef SHARED_REG_ARB_LOCK_EN
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      q_q     <= q_d;
      ptr_q   <= ptr_d;
      fire_q  <= fire_d;
      src_q   <= src_d;
`ifdef SHARED_REG_ARB_LOCK_EN
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign q_out   = q_q;
  assign wr_fire = fire_q;
  assign wr_src  = src_q;

endmodule
